// File: rtl/bnn_seq_pkg.sv
// Shared definitions for the BNN host-side sequencer: FSM states,
// bnn_ui bit positions and the default parameter-chain length.
package bnn_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CFG_BIT  = 3'd1,
    S_CFG_WAIT = 3'd2,
    S_INF_LO   = 3'd3,
    S_INF_HI   = 3'd4,
    S_SETTLE   = 3'd5,
    S_RESP     = 3'd6
  } state_t;

  // Bit positions inside the core's dedicated input bus.
  localparam int UI_CLK     = 0;
  localparam int UI_SETUP   = 1;
  localparam int UI_PARAM   = 2;
  localparam int UI_BANK    = 3;
  localparam int UI_NIB_LSB = 4;

  // Parameter-chain length of the reference network build.
  localparam int DEFAULT_CHAIN_LEN = 144;

  // Bit counter never wraps, so an overlong load can not alias to a good one.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/bnn_tick_gen.sv
// One user-clock tick: CLK_HALF low cycles then CLK_HALF high cycles.
// The high-phase output is a flop, so the user clock it drives is glitch-free.
module bnn_tick_gen #(
  parameter int CLK_HALF = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  output logic busy_o,
  output logic high_o,
  output logic first_low_o,
  output logic done_o
);

  localparam logic [15:0] HALF = 16'(CLK_HALF);
  localparam logic [15:0] LAST = 16'(2 * CLK_HALF - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        high_q, high_d;

  // Phase counter: a start (re)arms the tick even in its final cycle,
  // which lets ticks run back to back with no gap.
  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    high_d = high_q;
    if (start_i) begin
      cnt_d  = 16'd0;
      busy_d = 1'b1;
      high_d = 1'b0;
    end else if (busy_q) begin
      if (cnt_q == LAST) begin
        cnt_d  = 16'd0;
        busy_d = 1'b0;
        high_d = 1'b0;
      end else begin
        cnt_d  = cnt_q + 16'd1;
        high_d = ((cnt_q + 16'd1) >= HALF);
      end
    end
  end

  // Phase state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= 16'd0;
      busy_q <= 1'b0;
      high_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      high_q <= high_d;
    end
  end

  assign busy_o      = busy_q;
  assign high_o      = high_q;
  assign first_low_o = busy_q && (cnt_q == 16'd0);
  assign done_o      = busy_q && (cnt_q == LAST);

endmodule

// File: rtl/bnn_sequencer.sv
// Host-side controller for the serial-configured BNN core: shifts config
// bytes into the parameter chain, presents inference inputs as two nibble
// ticks, then samples and holds the network output.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid must not depend on ready. In IDLE a config byte has
// priority, so an infer_valid seen together with cfg_valid is not taken
// even though infer_ready may be high in that cycle.
module bnn_sequencer
  import bnn_seq_pkg::*;
#(
  parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN,
  parameter int CLK_HALF  = 1,
  parameter int SETTLE    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_data,
  input  logic       cfg_last,
  input  logic       infer_valid,
  output logic       infer_ready,
  input  logic [7:0] infer_x,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_y,
  output logic       configured,
  output logic       cfg_err,
  output logic [7:0] bnn_ui,
  input  logic [7:0] bnn_uo,
  output logic [2:0] dbg_state
);

  state_t      state_q, state_d;
  logic        setup_q, setup_d;
  logic        param_q, param_d;
  logic        bank_q, bank_d;
  logic [3:0]  nib_q, nib_d;
  logic [7:0]  byte_q, byte_d;
  logic        last_q, last_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  x_q, x_d;
  logic [15:0] settle_q, settle_d;
  logic [7:0]  res_y_q, res_y_d;
  logic        configured_q, configured_d;
  logic        cfg_err_q, cfg_err_d;
  logic [15:0] bit_cnt_q, bit_cnt_d;

  logic tick_start, tick_busy, tick_high, tick_first, tick_done;
  logic take_byte, take_first;

  bnn_tick_gen #(
    .CLK_HALF(CLK_HALF)
  ) u_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (tick_start),
    .busy_o     (tick_busy),
    .high_o     (tick_high),
    .first_low_o(tick_first),
    .done_o     (tick_done)
  );

  // A new byte is never handed over while a tick is still in flight.
  assign cfg_ready   = ((state_q == S_IDLE) || (state_q == S_CFG_WAIT)) && !tick_busy;
  assign infer_ready = (state_q == S_IDLE) && configured_q && !tick_busy;

  // Next-state and datapath updates; data fields only move on the edge that
  // starts a tick, so they are stable for the whole tick.
  always_comb begin
    state_d      = state_q;
    setup_d      = setup_q;
    param_d      = param_q;
    bank_d       = bank_q;
    nib_d        = nib_q;
    byte_d       = byte_q;
    last_d       = last_q;
    bit_idx_d    = bit_idx_q;
    x_d          = x_q;
    settle_d     = settle_q;
    res_y_d      = res_y_q;
    configured_d = configured_q;
    cfg_err_d    = cfg_err_q;
    bit_cnt_d    = bit_cnt_q;
    tick_start   = 1'b0;
    take_byte    = 1'b0;
    take_first   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cfg_valid && cfg_ready) begin
          take_byte  = 1'b1;
          take_first = 1'b1;
        end else if (infer_valid && infer_ready) begin
          state_d    = S_INF_LO;
          x_d        = infer_x;
          setup_d    = 1'b0;
          param_d    = 1'b0;
          bank_d     = 1'b0;
          nib_d      = infer_x[3:0];
          tick_start = 1'b1;
        end
      end

      S_CFG_BIT: begin
        if (tick_first) begin
          bit_cnt_d = sat_inc16(bit_cnt_q);
        end
        if (tick_done) begin
          if (bit_idx_q == 3'd7) begin
            if (last_q) begin
              state_d = S_IDLE;
              setup_d = 1'b0;
              param_d = 1'b0;
              if (bit_cnt_q == 16'(CHAIN_LEN)) begin
                configured_d = 1'b1;
                cfg_err_d    = 1'b0;
              end else begin
                configured_d = 1'b0;
                cfg_err_d    = 1'b1;
              end
            end else begin
              state_d = S_CFG_WAIT;
            end
          end else begin
            bit_idx_d  = bit_idx_q + 3'd1;
            param_d    = byte_q[bit_idx_q + 3'd1];
            tick_start = 1'b1;
          end
        end
      end

      S_CFG_WAIT: begin
        if (cfg_valid && cfg_ready) begin
          take_byte = 1'b1;
        end
      end

      S_INF_LO: begin
        if (tick_done) begin
          state_d    = S_INF_HI;
          bank_d     = 1'b1;
          nib_d      = x_q[7:4];
          tick_start = 1'b1;
        end
      end

      S_INF_HI: begin
        if (tick_done) begin
          state_d  = S_SETTLE;
          settle_d = 16'd0;
        end
      end

      S_SETTLE: begin
        if (settle_q == 16'(SETTLE - 1)) begin
          state_d = S_RESP;
          res_y_d = bnn_uo;
        end else begin
          settle_d = settle_q + 16'd1;
        end
      end

      S_RESP: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Byte acceptance is shared by IDLE and CFG_WAIT; only a byte taken from
    // IDLE starts a fresh load and forgets the previous load's outcome.
    if (take_byte) begin
      state_d    = S_CFG_BIT;
      byte_d     = cfg_data;
      last_d     = cfg_last;
      bit_idx_d  = 3'd0;
      setup_d    = 1'b1;
      param_d    = cfg_data[0];
      bank_d     = 1'b0;
      nib_d      = 4'd0;
      tick_start = 1'b1;
      if (take_first) begin
        bit_cnt_d    = 16'd0;
        configured_d = 1'b0;
        cfg_err_d    = 1'b0;
      end
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      setup_q      <= 1'b0;
      param_q      <= 1'b0;
      bank_q       <= 1'b0;
      nib_q        <= 4'd0;
      byte_q       <= 8'd0;
      last_q       <= 1'b0;
      bit_idx_q    <= 3'd0;
      x_q          <= 8'd0;
      settle_q     <= 16'd0;
      res_y_q      <= 8'd0;
      configured_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      bit_cnt_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      setup_q      <= setup_d;
      param_q      <= param_d;
      bank_q       <= bank_d;
      nib_q        <= nib_d;
      byte_q       <= byte_d;
      last_q       <= last_d;
      bit_idx_q    <= bit_idx_d;
      x_q          <= x_d;
      settle_q     <= settle_d;
      res_y_q      <= res_y_d;
      configured_q <= configured_d;
      cfg_err_q    <= cfg_err_d;
      bit_cnt_q    <= bit_cnt_d;
    end
  end

  // Core bus assembly; every field comes straight from a flop.
  always_comb begin
    bnn_ui                       = 8'd0;
    bnn_ui[UI_CLK]               = tick_high;
    bnn_ui[UI_SETUP]             = setup_q;
    bnn_ui[UI_PARAM]             = param_q;
    bnn_ui[UI_BANK]              = bank_q;
    bnn_ui[UI_NIB_LSB +: 4]      = nib_q;
  end

  assign res_valid  = (state_q == S_RESP);
  assign res_y      = res_y_q;
  assign configured = configured_q;
  assign cfg_err    = cfg_err_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/bnn_sequencer.md
# bnn_sequencer

Host-side controller for the serial-configured binary neural network core. It accepts configuration bytes and inference requests over valid/ready interfaces. It drives the core's 8-bit control/input bus directly: the generated user clock, setup, the serial parameter bit and the input nibbles. It then samples the 8-bit network output and returns it as a held result, so that software never has to bit-bang the core.

## Interface
Parameters:
- `CHAIN_LEN`, default 144: total parameter-chain bits of the instantiated network; the expected config length.
- `CLK_HALF`, default 1: system cycles per half period of the generated user clock (≥1).
- `SETTLE`, default 2: system cycles waited after the last input tick before sampling the output (≥1).

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset. Synchronous, active-low.
- `cfg_valid`, in, 1: config byte offered.
- `cfg_ready`, out, 1: config byte accepted when high together with `cfg_valid`.
- `cfg_data`, in, 8: parameter bits, shifted LSB first.
- `cfg_last`, in, 1: marks the final config byte.
- `infer_valid`, in, 1: inference request.
- `infer_ready`, out, 1: request accepted.
- `infer_x`, in, 8: network input vector.
- `res_valid`, out, 1: result available.
- `res_ready`, in, 1: result consumed.
- `res_y`, out, 8: sampled network output.
- `configured`, out, 1: a length-correct configuration has completed.
- `cfg_err`, out, 1: sticky flag; the last config load had the wrong bit count.
- `bnn_ui`, out, 8: drives the core's dedicated inputs. [0] user clock, [1] setup, [2] param bit, [3] bank select (high nibble), [7:4] nibble.
- `bnn_uo`, in, 8: core's dedicated outputs.

## Operation
- Tick: a low phase of `CLK_HALF` cycles with the data fields stable, then a high phase of `CLK_HALF` cycles with `bnn_ui[0]`=1. Data fields change only in the first low-phase cycle of a tick.
- States:
  - IDLE. `cfg_ready`=1. `infer_ready`=`configured`.
  - CFG_BIT: 8 ticks with setup=1, param bit = `cfg_data[k]` for k=0..7.
  - CFG_WAIT: setup held 1, `cfg_ready`=1, awaiting the next byte.
  - INF_LO: 1 tick with bank=0 and nibble=`infer_x[3:0]`.
  - INF_HI: 1 tick with bank=1 and nibble=`infer_x[7:4]`.
  - SETTLE: `SETTLE` cycles.
  - RESP: `res_valid`=1 and `res_y` frozen.
- Transitions:
  - IDLE → CFG_BIT on a config handshake. A config request takes priority over a simultaneous `infer_valid`.
  - IDLE → INF_LO on an inference handshake; `infer_x` is registered.
  - CFG_BIT → CFG_WAIT after 8 ticks if `cfg_last` of that byte was 0; otherwise → IDLE with setup dropped to 0.
  - CFG_WAIT → CFG_BIT on the next handshake. `infer_valid` is ignored while in CFG_WAIT.
  - INF_LO → INF_HI → SETTLE → RESP. `res_y` = `bnn_uo`, sampled in the last SETTLE cycle.
  - RESP → IDLE on `res_ready`.
- Bit counter: 16-bit, saturating. Cleared by the first byte accepted from IDLE, which also clears `cfg_err` and `configured`.
- On completion of the `cfg_last` byte: count == `CHAIN_LEN` sets `configured`=1; otherwise `cfg_err`=1 and `configured`=0. Excess bits are still shifted.
- Reset, including mid-operation:
  - Outputs: `bnn_ui`=0, `res_valid`=0, `res_y`=0, `configured`=0, `cfg_err`=0, `cfg_ready`=1, `infer_ready`=0.
  - State returns to IDLE. The core's parameters are considered lost and must be reloaded.

## Timing
- Config byte: accepted in cycle 0; 8 ticks occupy cycles 1..16·`CLK_HALF`. `cfg_ready` is high again in the following cycle.
- Inference latency: handshake in cycle 0; `res_valid` rises in cycle 4·`CLK_HALF`+`SETTLE`+1. With the defaults that is cycle 7.
- `res_valid` stays high and `res_y` stays stable until `res_ready`. No new request is accepted while a result is held.
- The user clock is always registered and glitch-free. Setup never toggles while the user clock is high.

## Structure
- Package `bnn_seq_pkg`:
  - state enum;
  - `bnn_ui` bit-index constants: CLK=0, SETUP=1, PARAM=2, BANK=3, NIB_LSB=4;
  - default `CHAIN_LEN`.
- Sub-module `bnn_tick_gen`: phase counter with start/busy/done, a high-phase output, and a first-low-cycle strobe. It is reused for both config and inference ticks.

## Test plan
- Load 18 bytes (144 bits) with the pattern 0xA5. Required:
  - `bnn_ui[2]` follows 1,0,1,0,0,1,0,1 per byte;
  - setup stays 1 throughout, including in CFG_WAIT;
  - `configured`=1 and `cfg_err`=0 after the last byte.
- Load 17 bytes with `cfg_last` on the 17th. Required: `cfg_err`=1, `configured`=0, `infer_ready` stays 0.
- After configuration, send `infer_x`=0x3C with the defaults. Required: nibble 0xC with bank=0, then 0x3 with bank=1; `res_valid` at cycle 7 with `res_y` = the `bnn_uo` model value.
- Hold `res_ready`=0 for 20 cycles while changing `bnn_uo`. Required: `res_y` stays unchanged and `infer_ready` stays 0.
- Assert `cfg_valid` and `infer_valid` in the same cycle while in IDLE. Required: the config byte wins and configured clears.
- Assert `rst_n`=0 for one cycle in the middle of a CFG_BIT tick. Required: every output takes its reset value the next cycle and the user clock is low.
